// File: rtl/hamming_rx_sequencer_if.sv
// rtl/hamming_rx_sequencer_if.sv - codeword input and decoded-result output handshake bundle
//
// Purpose: groups the two valid/ready channels of the SECDED receive sequencer.
// Signals:
//   in_valid / in_ready / in_code          : codeword channel (source -> decoder)
//   out_valid / out_ready / out_data /
//   out_code / out_single / out_double     : result channel (decoder -> sink)
// Modports:
//   master : source/sink side (drives in_valid, in_code, out_ready)
//   slave  : decoder side (drives in_ready and all result signals)

interface hamming_rx_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] out_code;
  logic       out_single;
  logic       out_double;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_code,
    input  out_single,
    input  out_double
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_code,
    output out_single,
    output out_double
  );
endinterface

// File: rtl/hamming_rx_sequencer.sv
// rtl/hamming_rx_sequencer.sv - SECDED (8,4) codeword receive, correct and statistics sequencer
//
// Purpose: accepts one SECDED codeword at a time, decodes it over a fixed
// three-state sequence (IDLE -> DECODE -> HOLD), presents the corrected word
// until the sink takes it, and keeps saturating error/word statistics.
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   bus        : codeword in / result out handshake bundle (slave side)
//   clr_stats  : synchronous clear of the statistics counters
//   single_cnt : saturating count of delivered words with a corrected single error
//   double_cnt : saturating count of delivered words with an uncorrectable double error
//   word_cnt   : saturating count of delivered words
//   busy       : high whenever the sequencer is not idle

module hamming_rx_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_rx_sequencer_if.slave bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     single_cnt,
  output logic [CNT_W-1:0]     double_cnt,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic       in_ready_c;
  logic       out_valid_c;
  logic       busy_c;

  logic [7:0] cap_code;

  logic [2:0] syndrome;
  logic       overall_err;
  logic [7:0] flip_mask;
  logic [7:0] fixed_code;
  logic       is_single;
  logic       is_double;

  logic [3:0] data_q;
  logic [7:0] code_q;
  logic       single_q;
  logic       double_q;

  logic       accept;
  logic       deliver;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign deliver = (state == HOLD) && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = DECODE;
      DECODE:  state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend on state only, so neither handshake side sees a
  // combinational path from the opposite direction.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
      end
      HOLD:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign busy          = busy_c;

  // in_code is sampled only on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_code <= 8'h00;
    end else if (accept) begin
      cap_code <= bus.in_code;
    end
  end

  // Bit i of the codeword is Hamming position i+1; bit 7 is overall parity.
  always_comb begin
    syndrome[0] = cap_code[0] ^ cap_code[2] ^ cap_code[4] ^ cap_code[6];
    syndrome[1] = cap_code[1] ^ cap_code[2] ^ cap_code[5] ^ cap_code[6];
    syndrome[2] = cap_code[3] ^ cap_code[4] ^ cap_code[5] ^ cap_code[6];
    overall_err = ^cap_code;

    // A zero syndrome with bad overall parity means the parity bit itself flipped.
    if (syndrome == 3'd0) begin
      flip_mask = 8'h80;
    end else begin
      flip_mask = 8'h01 << (syndrome - 3'd1);
    end

    is_single  = overall_err;
    is_double  = !overall_err && (syndrome != 3'd0);
    fixed_code = overall_err ? (cap_code ^ flip_mask) : cap_code;
  end

  // Result registers: loaded in DECODE, held unchanged through HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= 4'h0;
      code_q   <= 8'h00;
      single_q <= 1'b0;
      double_q <= 1'b0;
    end else if (state == DECODE) begin
      data_q   <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
      code_q   <= fixed_code;
      single_q <= is_single;
      double_q <= is_double;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_code   = code_q;
  assign bus.out_single = single_q;
  assign bus.out_double = double_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  // Statistics update once per delivered word; a coincident clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      word_cnt   <= '0;
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (deliver) begin
      word_cnt <= sat_inc(word_cnt);
      if (single_q) single_cnt <= sat_inc(single_cnt);
      if (double_q) double_cnt <= sat_inc(double_cnt);
    end
  end

endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// tb/tb_hamming_rx_sequencer.sv - self-checking bench for hamming_rx_sequencer

module tb_hamming_rx_sequencer;

  localparam int CNT_W   = 4;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] data;
    logic       single;
    logic       dbl;
  } res_t;

  typedef struct {
    logic [7:0] code;
    res_t       exp;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             clr_stats;
  logic [CNT_W-1:0] single_cnt;
  logic [CNT_W-1:0] double_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic             busy;

  hamming_rx_sequencer_if bus ();

  hamming_rx_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .single_cnt (single_cnt),
    .double_cnt (double_cnt),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_word = 0;
  int m_single = 0;
  int m_double = 0;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference decoder: the syndrome of a single-error word is the position of
  // the flipped bit, i.e. the XOR of the positions of all set bits.
  function automatic res_t model(input logic [7:0] c);
    res_t r;
    int syn;
    int ones;
    syn  = 0;
    ones = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) syn = syn ^ p;
    for (int b = 0; b < 8; b++) if (c[b]) ones++;
    r.code   = c;
    r.single = 1'b0;
    r.dbl    = 1'b0;
    if (ones % 2 == 1) begin
      r.single = 1'b1;
      if (syn == 0) r.code[7] = ~c[7];
      else          r.code[syn-1] = ~c[syn-1];
    end else if (syn != 0) begin
      r.dbl = 1'b1;
    end
    r.data = {r.code[6], r.code[5], r.code[4], r.code[2]};
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v >= SAT_MAX) ? SAT_MAX : v + 1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_word_cnt"},   32'(word_cnt),   m_word);
    check({tag, "_single_cnt"}, 32'(single_cnt), m_single);
    check({tag, "_double_cnt"}, 32'(double_cnt), m_double);
  endtask

  task automatic send_word(input logic [7:0] code, input res_t exp, input int stall, input bit clr);
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_code  = 8'($urandom);
    check("decode_out_valid", 32'(bus.out_valid), 0);
    check("decode_in_ready",  32'(bus.in_ready),  0);
    check("decode_busy",      32'(busy),          1);
    @(posedge clk);
    @(negedge clk);
    check("latency_out_valid", 32'(bus.out_valid),  1);
    check("out_code",          32'(bus.out_code),   32'(exp.code));
    check("out_data",          32'(bus.out_data),   32'(exp.data));
    check("out_single",        32'(bus.out_single), 32'(exp.single));
    check("out_double",        32'(bus.out_double), 32'(exp.dbl));
    check("flags_exclusive",   32'(bus.out_single & bus.out_double), 0);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_code  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_out_code",  32'(bus.out_code),  32'(exp.code));
      check("hold_out_data",  32'(bus.out_data),  32'(exp.data));
      check("hold_in_ready",  32'(bus.in_ready),  0);
      check("hold_word_cnt",  32'(word_cnt),      m_word);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clr_stats     = clr;
    @(posedge clk);
    if (clr) begin
      m_word   = 0;
      m_single = 0;
      m_double = 0;
    end else begin
      m_word = sat(m_word);
      if (exp.single) m_single = sat(m_single);
      if (exp.dbl)    m_double = sat(m_double);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    clr_stats     = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 0);
    check("post_in_ready",  32'(bus.in_ready),  1);
    check_counters("post");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] code;

    tbl[0] = '{8'h55, '{8'h55, 4'b1011, 1'b0, 1'b0}};
    tbl[1] = '{8'h45, '{8'h55, 4'b1011, 1'b1, 1'b0}};
    tbl[2] = '{8'hD5, '{8'h55, 4'b1011, 1'b1, 1'b0}};
    tbl[3] = '{8'h56, '{8'h56, 4'b1011, 1'b0, 1'b1}};
    tbl[4] = '{8'h00, '{8'h00, 4'b0000, 1'b0, 1'b0}};
    tbl[5] = '{8'h54, '{8'h55, 4'b1011, 1'b1, 1'b0}};
    tbl[6] = '{8'hFF, '{8'hFF, 4'b1111, 1'b0, 1'b0}};
    tbl[7] = '{8'h01, '{8'h00, 4'b0000, 1'b1, 1'b0}};

    rst_n         = 1'b0;
    clr_stats     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   32'(bus.in_ready),   1);
    check("rst_out_valid",  32'(bus.out_valid),  0);
    check("rst_out_single", 32'(bus.out_single), 0);
    check("rst_out_double", 32'(bus.out_double), 0);
    check("rst_out_data",   32'(bus.out_data),   0);
    check("rst_out_code",   32'(bus.out_code),   0);
    check("rst_busy",       32'(busy),           0);
    check_counters("rst");

    // Directed vectors; entry 1 also exercises a 5-cycle backpressure stall.
    for (int i = 0; i < 8; i++) begin
      send_word(tbl[i].code, tbl[i].exp, (i == 1) ? 5 : i % 3, 1'b0);
    end

    // Random codewords against the reference model, with occasional clears.
    for (int i = 0; i < 40; i++) begin
      code = 8'($urandom);
      send_word(code, model(code), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // Standalone clear while idle.
    @(negedge clk);
    clr_stats = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_stats = 1'b0;
    m_word   = 0;
    m_single = 0;
    m_double = 0;
    check_counters("clr_idle");

    // Saturation: 20 single-error words, then a clear on the 21st handshake.
    for (int i = 0; i < 20; i++) begin
      code = 8'h55 ^ (8'h01 << $urandom_range(0, 7));
      send_word(code, model(code), 0, 1'b0);
    end
    check("sat_single_cnt", 32'(single_cnt), 15);
    check("sat_word_cnt",   32'(word_cnt),   15);
    code = 8'h45;
    send_word(code, model(code), 0, 1'b1);
    check("sat_clr_single_cnt", 32'(single_cnt), 0);

    // Mid-operation reset while holding a result.
    send_word(8'h56, model(8'h56), 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_code  = 8'h45;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_hold_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    m_word   = 0;
    m_single = 0;
    m_double = 0;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready",  32'(bus.in_ready),  1);
    check("midrst_busy",      32'(busy),          0);
    check_counters("midrst");
    send_word(8'h45, model(8'h45), 1, 1'b0);
    check("midrst_next_word_cnt", 32'(word_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
